// File: rtl/mii_mac_tx.sv
// mii_mac_tx: turns a byte stream into MII nibbles with preamble, SFD, zero pad, CRC-32 FCS and inter-packet gap.
// Latency: first tx_en at the first ce edge with valid in IDLE; each byte's low nibble leaves on its accept edge.
// Backpressure: ready only in byte-fetch ce slots; an empty fetch slot aborts the frame and drains input up to last.
module mii_mac_tx #(
  parameter int IPG_NIBBLES = 24,
  parameter bit PAD         = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic [7:0] data,
  input  logic       valid,
  input  logic       last,
  input  logic       err,
  output logic       ready,
  output logic       tx_en,
  output logic [3:0] txd,
  output logic       tx_er
);

  // One counter serves preamble, FCS nibble index and IPG, so size it for the largest.
  localparam int CW = $clog2(IPG_NIBBLES + 16);
  localparam logic [CW-1:0] PRE_LAST = CW'(14);
  localparam logic [CW-1:0] FCS_LAST = CW'(7);
  localparam logic [CW-1:0] IPG_LAST = CW'(IPG_NIBBLES - 1);
  localparam logic [31:0]   POLY     = 32'hEDB88320;
  localparam logic [5:0]    MIN_LEN  = 6'd60;

  // Each state names the nibble produced at the next ce edge. DATA_LO is the byte-fetch slot:
  // SFD and the high nibble of a non-last byte both lead into it.
  typedef enum logic [3:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_DATA_LO, S_DATA_HI, S_PAD, S_FCS, S_IPG, S_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   crc_q, crc_d;
  logic [5:0]    byte_cnt_q, byte_cnt_d;
  logic [3:0]    hi_q, hi_d;
  logic          err_q, err_d;
  logic          last_q, last_d;
  logic          pad_hi_q, pad_hi_d;
  logic          tx_en_q, tx_en_d;
  logic          tx_er_q, tx_er_d;
  logic [3:0]    txd_q, txd_d;
  logic [31:0]   fcs_sh;

  // Reflected CRC-32 advanced by one nibble, LSB first (wire order).
  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] n);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      r = (r[0] ^ n[i]) ? ((r >> 1) ^ POLY) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == MIN_LEN) ? MIN_LEN : v + 6'd1;
  endfunction

  // Drain swallows bytes every clk so a starved source can flush its frame quickly.
  assign ready  = (state_q == S_DRAIN) || (ce && (state_q == S_DATA_LO));
  assign fcs_sh = ~crc_q >> {cnt_q[2:0], 2'b00};

  assign tx_en = tx_en_q;
  assign txd   = txd_q;
  assign tx_er = tx_er_q;

  // State, CRC, counters and registered MII outputs; reset drops the line immediately.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      crc_q      <= '1;
      byte_cnt_q <= '0;
      hi_q       <= '0;
      err_q      <= 1'b0;
      last_q     <= 1'b0;
      pad_hi_q   <= 1'b0;
      tx_en_q    <= 1'b0;
      txd_q      <= '0;
      tx_er_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      byte_cnt_q <= byte_cnt_d;
      hi_q       <= hi_d;
      err_q      <= err_d;
      last_q     <= last_d;
      pad_hi_q   <= pad_hi_d;
      tx_en_q    <= tx_en_d;
      txd_q      <= txd_d;
      tx_er_q    <= tx_er_d;
    end
  end

  // Next-state and next-nibble selection; everything holds between ce cycles except drain progress.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    byte_cnt_d = byte_cnt_q;
    hi_d       = hi_q;
    err_d      = err_q;
    last_d     = last_q;
    pad_hi_d   = pad_hi_q;
    tx_en_d    = tx_en_q;
    txd_d      = txd_q;
    tx_er_d    = tx_er_q;

    unique case (state_q)
      S_IDLE: begin
        if (ce) begin
          tx_en_d = 1'b0;
          txd_d   = 4'h0;
          tx_er_d = 1'b0;
          if (valid) begin
            tx_en_d = 1'b1;
            txd_d   = 4'h5;
            cnt_d   = CW'(1);
            state_d = S_PREAMBLE;
          end
        end
      end
      S_PREAMBLE: begin
        if (ce) begin
          tx_en_d = 1'b1;
          txd_d   = 4'h5;
          tx_er_d = 1'b0;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == PRE_LAST) state_d = S_SFD;
        end
      end
      S_SFD: begin
        if (ce) begin
          tx_en_d    = 1'b1;
          txd_d      = 4'hD;
          tx_er_d    = 1'b0;
          crc_d      = '1;
          byte_cnt_d = '0;
          state_d    = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (ce) begin
          tx_en_d = 1'b1;
          if (valid) begin
            txd_d      = data[3:0];
            tx_er_d    = err;
            hi_d       = data[7:4];
            err_d      = err;
            last_d     = last;
            crc_d      = crc_nib(crc_q, data[3:0]);
            byte_cnt_d = sat_inc(byte_cnt_q);
            state_d    = S_DATA_HI;
          end else begin
            // Source starved mid-frame: mark the frame bad on the wire and abandon it.
            txd_d   = 4'h0;
            tx_er_d = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      S_DATA_HI: begin
        if (ce) begin
          tx_en_d = 1'b1;
          txd_d   = hi_q;
          tx_er_d = err_q;
          crc_d   = crc_nib(crc_q, hi_q);
          if (!last_q) begin
            state_d = S_DATA_LO;
          end else if (PAD && (byte_cnt_q < MIN_LEN)) begin
            pad_hi_d = 1'b0;
            state_d  = S_PAD;
          end else begin
            cnt_d   = '0;
            state_d = S_FCS;
          end
        end
      end
      S_PAD: begin
        if (ce) begin
          tx_en_d  = 1'b1;
          txd_d    = 4'h0;
          tx_er_d  = 1'b0;
          crc_d    = crc_nib(crc_q, 4'h0);
          pad_hi_d = ~pad_hi_q;
          if (pad_hi_q) begin
            byte_cnt_d = sat_inc(byte_cnt_q);
            if (byte_cnt_q == MIN_LEN - 6'd1) begin
              cnt_d   = '0;
              state_d = S_FCS;
            end
          end
        end
      end
      S_FCS: begin
        if (ce) begin
          tx_en_d = 1'b1;
          txd_d   = fcs_sh[3:0];
          tx_er_d = 1'b0;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == FCS_LAST) begin
            cnt_d   = '0;
            state_d = S_IPG;
          end
        end
      end
      S_IPG: begin
        if (ce) begin
          tx_en_d = 1'b0;
          txd_d   = 4'h0;
          tx_er_d = 1'b0;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == IPG_LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        // The error nibble keeps its full ce slot; the line goes quiet on the next ce.
        if (ce) begin
          tx_en_d = 1'b0;
          txd_d   = 4'h0;
          tx_er_d = 1'b0;
        end
        if (valid && last) begin
          cnt_d   = '0;
          state_d = S_IPG;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mii_mac_tx.sv
// tb_mii_mac_tx: scoreboarded bench for mii_mac_tx with one unpadded and one padded instance.
// Expected nibbles are queued when a frame is scheduled and popped against each observed ce nibble.
// The selected instance is the only one that sees valid; the other stays idle.
`timescale 1ns/1ps
module tb_mii_mac_tx;

  logic       clk = 1'b0;
  logic       rst_n, ce, valid, last, err, sel;
  logic [7:0] data;
  logic       v0, v1, rdy0, rdy1, en0, en1, er0, er1;
  logic [3:0] d0, d1;
  logic       rdy, tx_en, tx_er;
  logic [3:0] txd;

  int checks = 0;
  int errors = 0;
  int ce_per = 1;
  int ce_ph  = 0;
  bit dead   = 1'b0;

  logic [5:0] obs_q[$];
  logic [5:0] exp_q[$];
  logic [7:0] fb_q[$];
  logic       fe_q[$];

  always #5 clk = ~clk;

  assign v0    = valid & ~sel;
  assign v1    = valid & sel;
  assign rdy   = sel ? rdy1 : rdy0;
  assign tx_en = sel ? en1 : en0;
  assign tx_er = sel ? er1 : er0;
  assign txd   = sel ? d1 : d0;

  mii_mac_tx #(.IPG_NIBBLES(24), .PAD(1'b0)) u_nopad (
    .clk(clk), .rst_n(rst_n), .ce(ce), .data(data), .valid(v0), .last(last), .err(err),
    .ready(rdy0), .tx_en(en0), .txd(d0), .tx_er(er0));

  mii_mac_tx #(.IPG_NIBBLES(24), .PAD(1'b1)) u_pad (
    .clk(clk), .rst_n(rst_n), .ce(ce), .data(data), .valid(v1), .last(last), .err(err),
    .ready(rdy1), .tx_en(en1), .txd(d1), .tx_er(er1));

  // ce cadence: high every ce_per clocks, changed on the falling edge.
  initial begin
    ce = 1'b0;
    forever begin
      @(negedge clk);
      if (ce_per <= 1) ce = 1'b1;
      else begin
        ce_ph = (ce_ph + 1) % ce_per;
        ce    = (ce_ph == 0);
      end
    end
  end

  // Record every nibble the selected instance launches on a ce edge.
  initial begin
    forever begin
      @(posedge clk);
      if (ce) begin
        #1;
        obs_q.push_back({tx_en, tx_er, txd});
      end
    end
  end

  task automatic pop_obs(input bit skip_idle, output logic [5:0] o);
    int t;
    t = 0;
    o = 6'h3F;
    if (dead) return;
    forever begin
      while (obs_q.size() == 0 && t < 3000) begin
        @(posedge clk);
        #2;
        t++;
      end
      if (obs_q.size() == 0) begin
        checks++;
        errors++;
        dead = 1'b1;
        $display("FAIL obs_timeout: no nibble after %0d clk, required one", t);
        return;
      end
      o = obs_q.pop_front();
      if (!(skip_idle && !o[5])) return;
    end
  endtask

  function automatic void push_nib(input logic en, input logic er, input logic [3:0] d);
    exp_q.push_back({en, er, d});
  endfunction

  function automatic void push_pre();
    for (int i = 0; i < 15; i++) push_nib(1'b1, 1'b0, 4'h5);
    push_nib(1'b1, 1'b0, 4'hD);
  endfunction

  function automatic void push_idle(input int n);
    for (int i = 0; i < n; i++) push_nib(1'b0, 1'b0, 4'h0);
  endfunction

  // Reference frame: byte-wise CRC-32 over data plus pad, FCS sent complemented, LS nibble first.
  function automatic void push_frame(input bit pad);
    logic [31:0] crc;
    logic [7:0]  b;
    logic        e;
    int          n;
    int          len;
    crc = 32'hFFFFFFFF;
    n   = fb_q.size();
    len = (pad && n < 60) ? 60 : n;
    push_pre();
    for (int i = 0; i < len; i++) begin
      b = (i < n) ? fb_q[i] : 8'h00;
      e = (i < n) ? fe_q[i] : 1'b0;
      push_nib(1'b1, e, b[3:0]);
      push_nib(1'b1, e, b[7:4]);
      crc = crc ^ {24'h0, b};
      for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
    end
    crc = ~crc;
    for (int k = 0; k < 8; k++) push_nib(1'b1, 1'b0, crc[4*k +: 4]);
  endfunction

  function automatic void set_frame(input int n, input logic [7:0] base, input int err_idx);
    fb_q.delete();
    fe_q.delete();
    for (int i = 0; i < n; i++) begin
      fb_q.push_back(base + 8'(i));
      fe_q.push_back(i == err_idx);
    end
  endfunction

  // Source: presents fb_q bytes, optionally starving before byte gap_at for gap_len clocks.
  task automatic feed(input int gap_at, input int gap_len, input bit hold);
    int n;
    int t;
    n = fb_q.size();
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        @(negedge clk);
        valid = 1'b0;
        repeat (gap_len) @(negedge clk);
      end
      @(negedge clk);
      data  = fb_q[i];
      err   = fe_q[i];
      last  = (i == n - 1);
      valid = 1'b1;
      #1;
      t = 0;
      if (gap_at >= 0 && i >= gap_at) begin
        checks++;
        if (rdy !== 1'b1) begin
          errors++;
          $display("FAIL drain_ready byte %0d: ready %b, required 1", i, rdy);
        end
      end
      while (rdy !== 1'b1 && t < 3000) begin
        @(negedge clk);
        #1;
        t++;
      end
      if (rdy !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL feed_timeout byte %0d: ready %b after %0d clk, required 1", i, rdy, t);
        valid = 1'b0;
        return;
      end
    end
    if (!hold) begin
      @(negedge clk);
      valid = 1'b0;
      last  = 1'b0;
      err   = 1'b0;
    end
  endtask

  task automatic settle();
    repeat (200) @(negedge clk);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ce_per = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({en0, er0, d0} !== 6'h0) begin errors++; $display("FAIL reset_out_nopad: got %h, required 00", {en0, er0, d0}); end
    checks++;
    if ({en1, er1, d1} !== 6'h0) begin errors++; $display("FAIL reset_out_pad: got %h, required 00", {en1, er1, d1}); end
    checks++;
    if ({rdy0, rdy1} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b, required 00", {rdy0, rdy1}); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if ({rdy0, rdy1, en0, en1} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_quiet: ready/tx_en %b, required 0000", {rdy0, rdy1, en0, en1});
    end
  endtask

  task automatic test_nopad_crc();
    logic [5:0] o, e;
    logic [3:0] fcs_k [8] = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
    sel = 1'b0;
    ce_per = 4;
    settle();
    set_frame(9, 8'h31, -1);
    push_pre();
    for (int i = 0; i < 9; i++) begin
      push_nib(1'b1, 1'b0, fb_q[i][3:0]);
      push_nib(1'b1, 1'b0, fb_q[i][7:4]);
    end
    for (int k = 0; k < 8; k++) push_nib(1'b1, 1'b0, fcs_k[k]);
    push_idle(24);
    fork
      feed(-1, 0, 1'b0);
      for (int i = 0; exp_q.size() > 0; i++) begin
        e = exp_q.pop_front();
        pop_obs(i == 0, o);
        checks++;
        if (o !== e) begin errors++; $display("FAIL nopad_crc nib %0d: got %h, required %h", i, o, e); end
      end
    join
  endtask

  task automatic test_pad();
    logic [5:0]  o, e;
    logic [31:0] res;
    int          en_cnt;
    res = 32'hFFFFFFFF;
    en_cnt = 0;
    sel = 1'b1;
    ce_per = 1;
    settle();
    set_frame(1, 8'hAB, -1);
    push_frame(1'b1);
    push_idle(4);
    fork
      feed(-1, 0, 1'b0);
      for (int i = 0; exp_q.size() > 0; i++) begin
        e = exp_q.pop_front();
        pop_obs(i == 0, o);
        if (o[5]) en_cnt++;
        if (o[5] && i >= 16 && i < 144)
          for (int b = 0; b < 4; b++) res = (res[0] ^ o[b]) ? ((res >> 1) ^ 32'hEDB88320) : (res >> 1);
        checks++;
        if (o !== e) begin errors++; $display("FAIL pad nib %0d: got %h, required %h", i, o, e); end
      end
    join
    checks++;
    if (en_cnt != 144) begin errors++; $display("FAIL pad_len: tx_en nibbles %0d, required 144", en_cnt); end
    checks++;
    if (res !== 32'hDEBB20E3) begin errors++; $display("FAIL pad_residue: got %h, required debb20e3", res); end
  endtask

  task automatic test_err();
    logic [5:0] o, e;
    sel = 1'b0;
    ce_per = 2;
    settle();
    set_frame(10, 8'h40, 4);
    push_frame(1'b0);
    push_idle(24);
    fork
      feed(-1, 0, 1'b0);
      for (int i = 0; exp_q.size() > 0; i++) begin
        e = exp_q.pop_front();
        pop_obs(i == 0, o);
        checks++;
        if (o !== e) begin errors++; $display("FAIL err_byte nib %0d: got %h, required %h", i, o, e); end
      end
    join
  endtask

  task automatic test_underflow();
    logic [5:0] o, e;
    sel = 1'b0;
    ce_per = 4;
    settle();
    set_frame(10, 8'h60, -1);
    push_pre();
    for (int i = 0; i < 3; i++) begin
      push_nib(1'b1, 1'b0, fb_q[i][3:0]);
      push_nib(1'b1, 1'b0, fb_q[i][7:4]);
    end
    push_nib(1'b1, 1'b1, 4'h0);
    push_idle(30);
    fork
      begin
        feed(3, 12, 1'b0);
        #1;
        checks++;
        if (rdy !== 1'b0) begin errors++; $display("FAIL underflow_ipg_ready: got %b, required 0", rdy); end
      end
      for (int i = 0; exp_q.size() > 0; i++) begin
        e = exp_q.pop_front();
        pop_obs(i == 0, o);
        checks++;
        if (o !== e) begin errors++; $display("FAIL underflow nib %0d: got %h, required %h", i, o, e); end
      end
    join
  endtask

  task automatic test_back_to_back();
    logic [5:0] o, e;
    sel = 1'b0;
    ce_per = 1;
    settle();
    set_frame(4, 8'h70, -1);
    push_frame(1'b0);
    push_idle(24);
    set_frame(4, 8'h80, -1);
    push_frame(1'b0);
    push_idle(4);
    fork
      begin
        set_frame(4, 8'h70, -1);
        feed(-1, 0, 1'b1);
        set_frame(4, 8'h80, -1);
        feed(-1, 0, 1'b0);
      end
      for (int i = 0; exp_q.size() > 0; i++) begin
        e = exp_q.pop_front();
        pop_obs(i == 0, o);
        checks++;
        if (o !== e) begin errors++; $display("FAIL back_to_back nib %0d: got %h, required %h", i, o, e); end
      end
    join
  endtask

  task automatic test_reset_fcs();
    logic [5:0] o, e;
    sel = 1'b1;
    ce_per = 1;
    settle();
    set_frame(1, 8'h55, -1);
    fork
      feed(-1, 0, 1'b0);
      for (int i = 0; i < 139; i++) pop_obs(i == 0, o);
    join
    checks++;
    if (o !== {2'b10, 4'h0} && o[5] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_fcs: got %h, required tx_en 1", o);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({en1, er1, d1} !== 6'h0) begin errors++; $display("FAIL reset_in_fcs: got %h, required 00", {en1, er1, d1}); end
    checks++;
    if (rdy1 !== 1'b0) begin errors++; $display("FAIL reset_in_fcs_ready: got %b, required 0", rdy1); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    obs_q.delete();
    exp_q.delete();
    set_frame(2, 8'hC3, -1);
    push_frame(1'b1);
    push_idle(4);
    fork
      feed(-1, 0, 1'b0);
      for (int i = 0; exp_q.size() > 0; i++) begin
        e = exp_q.pop_front();
        pop_obs(i == 0, o);
        checks++;
        if (o !== e) begin errors++; $display("FAIL after_reset nib %0d: got %h, required %h", i, o, e); end
      end
    join
  endtask

  initial begin
    rst_n = 1'b0;
    sel   = 1'b0;
    valid = 1'b0;
    data  = 8'h00;
    last  = 1'b0;
    err   = 1'b0;
    test_reset();
    test_nopad_crc();
    test_pad();
    test_err();
    test_underflow();
    test_back_to_back();
    test_reset_fcs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
